// File: rtl/gcdlcm_ctrl_if.sv
// rtl/gcdlcm_ctrl_if.sv - request/response bundle between the core and the GCD/LCM sequencer
interface gcdlcm_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;

  modport master (output start, op, opa, opb, input busy, done, result, ovf);
  modport slave  (input start, op, opa, opb, output busy, done, result, ovf);
endinterface

// File: rtl/gcdlcm_ctrl.sv
// rtl/gcdlcm_ctrl.sv - multi-cycle binary GCD with divide/multiply LCM tail
module gcdlcm_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input logic          clk,
  input logic          reset,
  gcdlcm_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, STRIP, NORMX, REDUCE, DIV, MUL, DONE} state_t;

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t             state;
  logic               opsel;
  logic [WIDTH-1:0]   a, b, x, y, q;
  logic [2*WIDTH-1:0] p;
  logic [CNTW-1:0]    k, cnt;
  logic [WIDTH:0]     trial, msum;
  logic [2*WIDTH-1:0] p_next;

  // After GCD, x is reused as the division remainder and y holds the divisor g.
  assign trial  = {x, q[WIDTH-1]};
  assign msum   = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (q[0] ? a : {WIDTH{1'b0}})};
  assign p_next = {msum, p[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      opsel      <= 1'b0;
      a          <= '0;
      b          <= '0;
      x          <= '0;
      y          <= '0;
      q          <= '0;
      p          <= '0;
      k          <= '0;
      cnt        <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.ovf    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.opa == '0 || bus.opb == '0) begin
              bus.result <= bus.op ? '0 : (bus.opa | bus.opb);
              bus.ovf    <= 1'b0;
              bus.done   <= 1'b1;
              state      <= DONE;
            end else begin
              a        <= bus.opa;
              b        <= bus.opb;
              opsel    <= bus.op;
              x        <= bus.opa;
              y        <= bus.opb;
              k        <= '0;
              bus.busy <= 1'b1;
              state    <= STRIP;
            end
          end
        end
        STRIP: begin
          if (!(x[0] | y[0])) begin
            x <= x >> 1;
            y <= y >> 1;
            k <= k + CNTW'(1);
          end else begin
            state <= NORMX;
          end
        end
        NORMX: begin
          if (!x[0]) x <= x >> 1;
          else       state <= REDUCE;
        end
        REDUCE: begin
          if (y == '0) begin
            if (!opsel) begin
              bus.result <= x << k;
              bus.ovf    <= 1'b0;
              bus.busy   <= 1'b0;
              bus.done   <= 1'b1;
              state      <= DONE;
            end else begin
              y     <= x << k;
              x     <= '0;
              q     <= b;
              cnt   <= '0;
              state <= DIV;
            end
          end else if (!y[0]) begin
            y <= y >> 1;
          end else if (x > y) begin
            x <= y;
            y <= x - y;
          end else begin
            y <= y - x;
          end
        end
        DIV: begin
          if (trial >= {1'b0, y}) begin
            x <= WIDTH'(trial - {1'b0, y});
            q <= {q[WIDTH-2:0], 1'b1};
          end else begin
            x <= trial[WIDTH-1:0];
            q <= {q[WIDTH-2:0], 1'b0};
          end
          if (cnt == LAST) begin
            cnt   <= '0;
            p     <= '0;
            state <= MUL;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        MUL: begin
          p <= p_next;
          q <= q >> 1;
          if (cnt == LAST) begin
            bus.result <= p_next[WIDTH-1:0];
            bus.ovf    <= |p_next[2*WIDTH-1:WIDTH];
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/gcdlcm_ctrl.md
Name: gcdlcm_ctrl

Overview:
Multi-cycle sequencer for the GCD/LCM coprocessor attached to the RISC-V core datapath. It accepts two unsigned operands and an op select, then runs binary (Stein) GCD. For LCM it follows with restoring division and shift-add multiplication, and returns a result and an overflow flag. The core holds its PC while busy is high and writes result back on done.

Parameters:
WIDTH, 32, operand/result width in bits (must be ≥ 4)
CNTW, $clog2(WIDTH)+1, width of the shift-count (k) and iteration counters

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; forces IDLE and clears all registers
start  input  1  request pulse; sampled only in IDLE
op  input  1  0 = GCD, 1 = LCM; sampled with start
opa  input  WIDTH  operand a, unsigned; sampled with start
opb  input  WIDTH  operand b, unsigned; sampled with start
busy  output  1  high in every state except IDLE and DONE
done  output  1  one-cycle pulse; result/ovf valid from this cycle on
result  output  WIDTH  GCD or LCM (low WIDTH bits); held until next DONE
ovf  output  1  LCM exceeds WIDTH bits; always 0 for GCD; held with result

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, result=0, ovf=0; x, y, k, q, p, counters = 0.
- States: IDLE, STRIP, NORMX, REDUCE, DIV, MUL, DONE. Exactly one register operation per cycle.
- IDLE:
  - start=0: stay in IDLE.
  - start=1 and (opa==0 or opb==0): go to DONE. Result = op ? 0 : (opa|opb); ovf=0. done asserts the cycle after start.
  - Otherwise: latch a=opa, b=opb, opsel=op; x=opa, y=opb, k=0; go to STRIP.
- STRIP: if x[0]|y[0]==0 → x>>=1, y>>=1, k++; else go to NORMX.
- NORMX: if x[0]==0 → x>>=1; else go to REDUCE.
- REDUCE (x odd invariant):
  - y==0: g = x<<k. GCD → DONE. LCM → DIV with dividend=b, divisor=g, counter=0.
  - y even: y>>=1.
  - y odd and x>y: x<=y, y<=x−y.
  - y odd and x≤y: y<=y−x.
- GCD-phase bound (STRIP+NORMX+REDUCE): at most 4*WIDTH cycles for any nonzero operands.
- DIV: restoring division, one quotient bit per cycle, MSB first, exactly WIDTH cycles. Produces q=b/g; the remainder is always 0. Then go to MUL with p=0, counter=0.
- MUL: shift-add a*q into a 2*WIDTH-bit p, one multiplier bit per cycle, exactly WIDTH cycles. Then go to DONE with result=p[WIDTH-1:0] and ovf=|p[2*WIDTH-1:WIDTH].
- DONE: done=1, busy=0 for exactly one cycle; result/ovf are registered on the transition into DONE. Next state is IDLE unconditionally; start is ignored in DONE.
- start while busy or in DONE: ignored, no queuing. op/opa/opb changes after acceptance have no effect.
- LCM total latency (start to done) = 1 + GCD phase + WIDTH + WIDTH + 1 cycles.
- Reset asserted mid-operation: immediate return to IDLE; outputs cleared; no done pulse.
- All arithmetic is unsigned. Subtractions in REDUCE never underflow because of the ordering above.

Test Plan:
- op=0, opa=48, opb=18 → single done pulse with result=6, ovf=0; busy high from cycle after start until DONE; latency ≤ 4*WIDTH+2.
- op=1, opa=4, opb=6 → result=12, ovf=0; latency equals the GCD-phase cycles + 2*WIDTH + 2 (check the DIV and MUL cycle counts are exactly WIDTH each).
- Zero operands: GCD(0,7)=7, GCD(7,0)=7, GCD(0,0)=0, LCM(0,7)=0 → done exactly 1 cycle after start, ovf=0.
- op=1, opa=0x00010000, opb=0x00010001 → result=0x00010000, ovf=1.
- GCD(1,0xFFFFFFFF)=1 and GCD(0x80000000,0x80000000)=0x80000000 → both complete within 4*WIDTH+2 cycles.
- Extra start pulses during busy (with different operands) are ignored and the original result is returned. Reset asserted mid-DIV → busy=0, result=0 immediately; a fresh GCD(48,18) afterwards returns 6.
